// File: rtl/hdmi_period_scheduler_pkg.sv
// Shared encodings and island geometry for the HDMI period scheduler.
package hdmi_pkg;

   localparam logic [2:0] PERIOD_CTRL         = 3'd0;
   localparam logic [2:0] PERIOD_VPRE         = 3'd1;
   localparam logic [2:0] PERIOD_VGUARD       = 3'd2;
   localparam logic [2:0] PERIOD_VIDEO        = 3'd3;
   localparam logic [2:0] PERIOD_DPRE         = 3'd4;
   localparam logic [2:0] PERIOD_DGUARD_LEAD  = 3'd5;
   localparam logic [2:0] PERIOD_DATA         = 3'd6;
   localparam logic [2:0] PERIOD_DGUARD_TRAIL = 3'd7;

   localparam logic [3:0] CTL_NONE = 4'b0000;
   localparam logic [3:0] CTL_VPRE = 4'b0001;
   localparam logic [3:0] CTL_DPRE = 4'b0101;

   localparam int PRE_LEN       = 8;
   localparam int GUARD_LEN     = 2;
   localparam int PKT_LEN       = 32;
   localparam int ISLAND_LEN    = PRE_LEN + 2 * GUARD_LEN + PKT_LEN;
   localparam int ISLAND_MARGIN = 12;
   localparam int VPRE_LEN      = 8;
   localparam int VGUARD_LEN    = 2;

   typedef enum logic [2:0] {
      ISL_IDLE,
      ISL_PRE,
      ISL_LGUARD,
      ISL_DATA,
      ISL_TGUARD
   } island_state_e;

   // The island must finish ISLAND_MARGIN clocks before the video preamble starts.
   function automatic logic island_fits(input int h_active, input int offset, input int h_total);
      return (h_active + offset + ISLAND_LEN + ISLAND_MARGIN) <= (h_total - VPRE_LEN - VGUARD_LEN);
   endfunction

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Packet handshake and TMDS period/timing bus between scheduler and encoders.
interface hdmi_period_scheduler_if;

   logic       aux_req;
   logic       aux_ack;
   logic       aux_active;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       de;
   logic       hsync;
   logic       vsync;
   logic [2:0] period;
   logic [3:0] ctl;

   modport master (
      input  aux_req,
      output aux_ack, aux_active, pix_x, pix_y, de, hsync, vsync, period, ctl
   );

   modport slave (
      output aux_req,
      input  aux_ack, aux_active, pix_x, pix_y, de, hsync, vsync, period, ctl
   );

endinterface

// File: rtl/hdmi_period_scheduler_raster_counter.sv
// Raster x/y counters with combinational sync, enable and video-preamble window flags.
module hdmi_raster_counter
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_TOTAL  = 525
) (
   input  logic       clk,
   input  logic       resetn,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       de_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       vpre_o,
   output logic       vguard_o
);

   logic [9:0] x_q;
   logic [9:0] x_d;
   logic [9:0] y_q;
   logic [9:0] y_d;
   logic       next_line_active_s;

   // Next raster position: x wraps at line end, y advances on that wrap.
   always_comb begin
      x_d = x_q + 10'd1;
      y_d = y_q;
      if (x_q == 10'(H_TOTAL - 1)) begin
         x_d = 10'd0;
         if (y_q == 10'(V_TOTAL - 1)) begin
            y_d = 10'd0;
         end else begin
            y_d = y_q + 10'd1;
         end
      end else begin
         x_d = x_q + 10'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q <= 10'd0;
         y_q <= 10'd0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Preamble/guard run on the tail of a line whose successor carries video.
   assign next_line_active_s = (y_q == 10'(V_TOTAL - 1)) || (y_q < 10'(V_ACTIVE - 1));

   assign x_o      = x_q;
   assign y_o      = y_q;
   assign de_o     = (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
   assign hsync_o  = (x_q >= 10'(H_ACTIVE + H_FRONT)) && (x_q < 10'(H_ACTIVE + H_FRONT + H_SYNC));
   assign vsync_o  = (y_q >= 10'(V_ACTIVE + V_FRONT)) && (y_q < 10'(V_ACTIVE + V_FRONT + V_SYNC));
   assign vpre_o   = next_line_active_s
                     && (x_q >= 10'(H_TOTAL - VPRE_LEN - VGUARD_LEN))
                     && (x_q < 10'(H_TOTAL - VGUARD_LEN));
   assign vguard_o = next_line_active_s && (x_q >= 10'(H_TOTAL - VGUARD_LEN));

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel-clock TMDS period sequencer: raster timing plus one data island per line.
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE      = 640,
   parameter int H_FRONT       = 16,
   parameter int H_SYNC        = 96,
   parameter int H_TOTAL       = 800,
   parameter int V_ACTIVE      = 480,
   parameter int V_FRONT       = 10,
   parameter int V_SYNC        = 2,
   parameter int V_TOTAL       = 525,
   parameter int ISLAND_OFFSET = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   hdmi_period_scheduler_if.master bus
);

   localparam logic ISLAND_FITS = island_fits(H_ACTIVE, ISLAND_OFFSET, H_TOTAL);

   logic [9:0]    x_s;
   logic [9:0]    y_s;
   logic          de_s;
   logic          hsync_s;
   logic          vsync_s;
   logic          vpre_s;
   logic          vguard_s;
   logic          start_s;

   island_state_e state_q;
   island_state_e state_d;
   island_state_e cur_state_s;
   logic [5:0]    cnt_q;
   logic [5:0]    cnt_d;
   logic [5:0]    cur_cnt_s;

   logic [2:0]    period_d;
   logic [3:0]    ctl_d;
   logic          aux_ack_d;
   logic          aux_active_d;

   logic [9:0]    pix_x_q;
   logic [9:0]    pix_y_q;
   logic          de_q;
   logic          hsync_q;
   logic          vsync_q;
   logic [2:0]    period_q;
   logic [3:0]    ctl_q;
   logic          aux_ack_q;
   logic          aux_active_q;

   hdmi_raster_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FRONT  (H_FRONT),
      .H_SYNC   (H_SYNC),
      .H_TOTAL  (H_TOTAL),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT),
      .V_SYNC   (V_SYNC),
      .V_TOTAL  (V_TOTAL)
   ) u_raster (
      .clk      (clk),
      .resetn   (resetn),
      .x_o      (x_s),
      .y_o      (y_s),
      .de_o     (de_s),
      .hsync_o  (hsync_s),
      .vsync_o  (vsync_s),
      .vpre_o   (vpre_s),
      .vguard_o (vguard_s)
   );

   assign start_s = ISLAND_FITS && (x_s == 10'(H_ACTIVE + ISLAND_OFFSET)) && bus.aux_req;

   // Island state for the current raster cycle (a grant takes effect in the start cycle itself) and its successor.
   always_comb begin
      cur_state_s = state_q;
      cur_cnt_s   = cnt_q;
      if ((state_q == ISL_IDLE) && start_s) begin
         cur_state_s = ISL_PRE;
         cur_cnt_s   = 6'(PRE_LEN - 1);
      end else begin
         cur_state_s = state_q;
         cur_cnt_s   = cnt_q;
      end

      state_d = cur_state_s;
      cnt_d   = cur_cnt_s - 6'd1;
      if ((cur_state_s == ISL_IDLE) || (cur_cnt_s == 6'd0)) begin
         case (cur_state_s)
            ISL_PRE: begin
               state_d = ISL_LGUARD;
               cnt_d   = 6'(GUARD_LEN - 1);
            end
            ISL_LGUARD: begin
               state_d = ISL_DATA;
               cnt_d   = 6'(PKT_LEN - 1);
            end
            ISL_DATA: begin
               state_d = ISL_TGUARD;
               cnt_d   = 6'(GUARD_LEN - 1);
            end
            default: begin
               state_d = ISL_IDLE;
               cnt_d   = 6'd0;
            end
         endcase
      end else begin
         state_d = cur_state_s;
         cnt_d   = cur_cnt_s - 6'd1;
      end
   end

   // Period selection, video periods first; island and video windows never overlap.
   always_comb begin
      period_d = PERIOD_CTRL;
      ctl_d    = CTL_NONE;
      if (de_s) begin
         period_d = PERIOD_VIDEO;
      end else if (vguard_s) begin
         period_d = PERIOD_VGUARD;
      end else if (vpre_s) begin
         period_d = PERIOD_VPRE;
         ctl_d    = CTL_VPRE;
      end else begin
         case (cur_state_s)
            ISL_PRE: begin
               period_d = PERIOD_DPRE;
               ctl_d    = CTL_DPRE;
            end
            ISL_LGUARD: period_d = PERIOD_DGUARD_LEAD;
            ISL_DATA:   period_d = PERIOD_DATA;
            ISL_TGUARD: period_d = PERIOD_DGUARD_TRAIL;
            default:    period_d = PERIOD_CTRL;
         endcase
      end
      aux_ack_d    = (cur_state_s == ISL_LGUARD) && (cur_cnt_s == 6'd0);
      aux_active_d = (cur_state_s == ISL_DATA);
   end

   // Island FSM and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ISL_IDLE;
         cnt_q        <= 6'd0;
         pix_x_q      <= 10'd0;
         pix_y_q      <= 10'd0;
         de_q         <= 1'b0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
         period_q     <= PERIOD_CTRL;
         ctl_q        <= CTL_NONE;
         aux_ack_q    <= 1'b0;
         aux_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pix_x_q      <= x_s;
         pix_y_q      <= y_s;
         de_q         <= de_s;
         hsync_q      <= hsync_s;
         vsync_q      <= vsync_s;
         period_q     <= period_d;
         ctl_q        <= ctl_d;
         aux_ack_q    <= aux_ack_d;
         aux_active_q <= aux_active_d;
      end
   end

   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.de         = de_q;
   assign bus.hsync      = hsync_q;
   assign bus.vsync      = vsync_q;
   assign bus.period     = period_q;
   assign bus.ctl        = ctl_q;
   assign bus.aux_ack    = aux_ack_q;
   assign bus.aux_active = aux_active_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Randomised self-checking bench: every output cycle is compared with a positional timing model.
module tb_hdmi_period_scheduler;

   localparam int HA  = 640;
   localparam int HF  = 16;
   localparam int HS  = 96;
   localparam int HT  = 800;
   localparam int VA  = 6;
   localparam int VF  = 2;
   localparam int VS  = 2;
   localparam int VT  = 12;
   localparam int OFF = 4;
   localparam int HT2 = 700;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   hdmi_period_scheduler_if bus_if ();
   hdmi_period_scheduler_if bus2_if ();

   hdmi_period_scheduler #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT), .ISLAND_OFFSET(OFF)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   // Line too short for an island: must never grant.
   hdmi_period_scheduler #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(20), .H_TOTAL(HT2),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT), .ISLAND_OFFSET(OFF)
   ) dut_nofit (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus2_if)
   );

   int checks = 0;
   int errors = 0;

   int cx, cy, isl_start, mode;
   int de_cnt, vs_lines, grants_line, hs_first, hs_last;
   bit exp_grant, vs_on_line, nofit_seen;
   bit fits;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (x=%0d y=%0d)", tag, got, exp, cx, cy);
      end
   endtask

   function automatic logic [31:0] observed();
      return {bus_if.pix_x, bus_if.pix_y, bus_if.de, bus_if.hsync, bus_if.vsync,
              bus_if.period, bus_if.ctl, bus_if.aux_ack, bus_if.aux_active};
   endfunction

   // Expected outputs for raster position (x,y); ph is the clock offset into the island or -1.
   function automatic logic [31:0] model(input int x, input int y, input int ph);
      logic       de, hs, vs, vline, ack, act;
      logic [2:0] per;
      logic [3:0] ctl;
      de    = (x < HA) && (y < VA);
      hs    = (x >= HA + HF) && (x < HA + HF + HS);
      vs    = (y >= VA + VF) && (y < VA + VF + VS);
      vline = (y == VT - 1) || (y < VA - 1);
      if (de)                            per = 3'd3;
      else if (vline && x >= HT - 2)     per = 3'd2;
      else if (vline && x >= HT - 10)    per = 3'd1;
      else if (ph < 0)                   per = 3'd0;
      else if (ph < 8)                   per = 3'd4;
      else if (ph < 10)                  per = 3'd5;
      else if (ph < 42)                  per = 3'd6;
      else                               per = 3'd7;
      ctl = (per == 3'd1) ? 4'b0001 : ((per == 3'd4) ? 4'b0101 : 4'b0000);
      ack = (ph == 9);
      act = (ph >= 10) && (ph < 42);
      return {10'(x), 10'(y), de, hs, vs, per, ctl, ack, act};
   endfunction

   function automatic logic req_for(input int m, input int x);
      case (m)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (x == HA + OFF + 1);
         3:       return (x == HA + OFF) || (x == HA + OFF + 1);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic clear_stats();
      de_cnt = 0; vs_lines = 0; grants_line = 0; exp_grant = 1'b0;
      vs_on_line = 1'b0; hs_first = -1; hs_last = -1; isl_start = -1;
   endtask

   task automatic step();
      logic        req;
      int          ph;
      logic [31:0] exp;
      req = req_for(mode, cx);
      bus_if.aux_req = req;
      if (cx == HA + OFF && req && fits) begin
         isl_start = cx;
         exp_grant = 1'b1;
      end
      ph  = (isl_start >= 0 && cx - isl_start < 44) ? cx - isl_start : -1;
      exp = model(cx, cy, ph);
      @(posedge clk);
      #1;
      chk("outs", observed(), exp);
      if (bus_if.de) de_cnt++;
      if (bus_if.aux_ack) grants_line++;
      if (bus_if.vsync) vs_on_line = 1'b1;
      if (bus_if.hsync) begin
         if (hs_first < 0) hs_first = int'(bus_if.pix_x);
         hs_last = int'(bus_if.pix_x);
      end
      if (bus2_if.aux_ack || bus2_if.aux_active) nofit_seen = 1'b1;
      cx++;
      if (cx == HT) begin
         chk("grants_line", 32'(grants_line), 32'(exp_grant));
         if (cy == 0) begin
            chk("hs_first", 32'(hs_first), 32'(HA + HF));
            chk("hs_last", 32'(hs_last), 32'(HA + HF + HS - 1));
         end
         if (vs_on_line) vs_lines++;
         cx = 0; isl_start = -1; grants_line = 0; exp_grant = 1'b0;
         vs_on_line = 1'b0; hs_first = -1; hs_last = -1;
         if (cy == VT - 1) begin
            chk("de_frame", 32'(de_cnt), 32'(HA * VA));
            chk("vs_lines", 32'(vs_lines), 32'(VS));
            de_cnt = 0; vs_lines = 0;
            cy = 0;
         end else begin
            cy++;
         end
      end
   endtask

   task automatic run_line(input int m);
      mode = m;
      for (int i = 0; i < HT; i++) step();
   endtask

   initial begin
      fits = ((HA + OFF + 44) + 12) <= (HT - 10);
      nofit_seen = 1'b0;
      bus_if.aux_req  = 1'b0;
      bus2_if.aux_req = 1'b1;
      cx = 0; cy = 0; mode = 0;
      clear_stats();

      #12;
      chk("reset_outs", observed(), 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Frame 1: directed modes on the first lines, random afterwards.
      for (int l = 0; l < VT; l++) begin
         run_line((l < 5) ? l : int'($urandom_range(0, 4)));
      end

      // Frame 2: reset in the middle of a packet.
      run_line(1);
      run_line(1);
      mode = 1;
      while (cx != 660) step();
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_active", 32'(bus_if.aux_active), 32'd0);
      chk("rst_outs", observed(), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cx = 0; cy = 0;
      clear_stats();
      run_line(1);
      run_line(4);
      run_line(0);

      chk("nofit_grant", 32'(nofit_seen), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
